// File: rtl/mux_pkg.sv
// Shared types and default sizing for the channel multiplexer.
package mux_pkg;

    typedef enum logic {
        MODE_FIXED,
        MODE_RR
    } mux_mode_t;

    localparam int unsigned DEFAULT_WIDTH    = 8;
    localparam int unsigned DEFAULT_CHANNELS = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search with a last-grant pointer; lowest priority goes to the last winner.
module rr_arbiter #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= IDX_W'(N - 1);
        end else if (advance) begin
            ptr_q <= grant_idx;
        end
    end

    // N is a power of two, so the IDX_W-bit add wraps the search for free.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!found && req[cand]) begin
                found              = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_mux_rr.sv
// N-channel to one registered multiplexer with fixed-select or round-robin arbitration.
module channel_mux_rr
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    mux_mode_t           mode_e;
    logic                load_en;
    logic                xfer;
    logic                advance;
    logic [CHANNELS-1:0] grant_onehot;
    logic [CHANNELS-1:0] ready_sel;
    logic [SEL_W-1:0]    grant_idx;
    logic [SEL_W-1:0]    pick_idx;

    assign mode_e  = mux_mode_t'(mode);
    assign load_en = !out_valid || out_ready;

    rr_arbiter #(
        .N     (CHANNELS),
        .IDX_W (SEL_W)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .req          (in_valid),
        .advance      (advance),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    always_comb begin
        ready_sel = '0;
        pick_idx  = sel;
        xfer      = 1'b0;
        if (mode_e == MODE_RR) begin
            ready_sel = grant_onehot;
            pick_idx  = grant_idx;
            xfer      = |in_valid;
        end else begin
            ready_sel[sel] = 1'b1;
            xfer           = in_valid[sel];
        end
        // Reset gating keeps in_ready low while reset is held, not just after it.
        if (!load_en || reset) begin
            ready_sel = '0;
            xfer      = 1'b0;
        end
    end

    assign in_ready = ready_sel;
    assign advance  = xfer && (mode_e == MODE_RR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= in_data[pick_idx*WIDTH +: WIDTH];
                out_chan <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_channel_mux_rr.sv
// Randomised and directed checks of channel_mux_rr against a transaction-level model.
module tb_channel_mux_rr;

    localparam int W  = 8;
    localparam int CH = 8;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_chan;
    logic            out_valid;
    logic            out_ready;

    int checks = 0;
    int errors = 0;

    // Model state
    bit         m_valid;
    logic [7:0] m_data;
    int         m_chan;
    int         m_ptr;

    channel_mux_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(int ptr, logic [CH-1:0] v);
        for (int i = 1; i <= CH; i++) begin
            if (v[(ptr + i) % CH]) return (ptr + i) % CH;
        end
        return -1;
    endfunction

    function automatic logic [CH-1:0] exp_ready();
        int g;
        if (reset || !(!m_valid || out_ready)) return '0;
        if (mode == 1'b0) return CH'(1) << sel;
        g = rr_pick(m_ptr, in_valid);
        if (g < 0) return '0;
        return CH'(1) << g;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = 8'h00;
        m_chan  = 0;
        m_ptr   = CH - 1;
    endtask

    task automatic model_step();
        int k;
        if (reset) begin
            model_reset();
        end else if (!m_valid || out_ready) begin
            k = (mode == 1'b0) ? ((in_valid[sel]) ? int'(sel) : -1) : rr_pick(m_ptr, in_valid);
            if (k >= 0) begin
                m_valid = 1;
                m_data  = in_data[k*W +: W];
                m_chan  = k;
                if (mode == 1'b1) m_ptr = k;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    // Advance one clock: model sees the same inputs the DUT samples, then settle.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_ramp_data();
        for (int k = 0; k < CH; k++) in_data[k*W +: W] = 8'(8'h10 + k);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset     = 1'b1;
        mode      = 1'b0;
        sel       = 3'd3;
        in_valid  = '1;
        out_ready = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({out_valid, out_data, out_chan, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h chan=%0d in_ready=%b, want all zero",
                     out_valid, out_data, out_chan, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fixed();
        set_ramp_data();
        mode      = 1'b0;
        sel       = 3'd3;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++;
            if (in_ready !== 8'h08) begin
                errors++;
                $display("FAIL fixed_ready: got %b want 00001000", in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h13 || out_chan !== 3'd3) begin
                errors++;
                $display("FAIL fixed_out: valid=%b data=%h chan=%0d want 1/13/3",
                         out_valid, out_data, out_chan);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rr_sweep();
        apply_reset();
        set_ramp_data();
        mode      = 1'b1;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_chan !== SW'(n % CH) || out_data !== 8'(8'h10 + n % CH)) begin
                errors++;
                $display("FAIL rr_sweep[%0d]: valid=%b chan=%0d data=%h want 1/%0d/%h",
                         n, out_valid, out_chan, out_data, n % CH, 8'h10 + n % CH);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        int exp_seq[4] = '{1, 7, 1, 7};
        apply_reset();
        mode      = 1'b1;
        in_valid  = 8'b1000_0010;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_chan !== SW'(exp_seq[n])) begin
                errors++;
                $display("FAIL rr_wrap[%0d]: valid=%b chan=%0d want 1/%0d",
                         n, out_valid, out_chan, exp_seq[n]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0]  held_d;
        logic [SW-1:0] held_c;
        mode      = 1'b1;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        held_d    = out_data;
        held_c    = out_chan;
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            in_valid = CH'($urandom) | 8'h01;
            for (int k = 0; k < CH; k++) in_data[k*W +: W] = 8'($urandom);
            mode = 1'($urandom);
            sel  = SW'($urandom);
            #1;
            checks++;
            if (in_ready !== '0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got %b want 0", n, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_chan !== held_c) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h chan=%0d want 1/%h/%0d",
                         n, out_valid, out_data, out_chan, held_d, held_c);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== exp_ready() || in_ready === '0) begin
            errors++;
            $display("FAIL stall_release_ready: got %b want %b", in_ready, exp_ready());
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== m_data || out_chan !== SW'(m_chan)) begin
            errors++;
            $display("FAIL stall_release_load: valid=%b data=%h chan=%0d want 1/%h/%0d",
                     out_valid, out_data, out_chan, m_data, m_chan);
        end
        @(negedge clk);
    endtask

    task automatic test_sel_change();
        set_ramp_data();
        mode      = 1'b0;
        sel       = 3'd2;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        out_ready = 1'b0;
        sel       = 3'd5;
        tick();
        checks++;
        if (out_chan !== 3'd2 || out_data !== 8'h12 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sel_change_hold: valid=%b chan=%0d data=%h want 1/2/12",
                     out_valid, out_chan, out_data);
        end
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_chan !== 3'd5 || out_data !== 8'h15 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sel_change_next: valid=%b chan=%0d data=%h want 1/5/15",
                     out_valid, out_chan, out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        set_ramp_data();
        mode      = 1'b1;
        in_valid  = 8'hF0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0 || in_ready !== '0) begin
            errors++;
            $display("FAIL reset_async: valid=%b data=%h chan=%0d in_ready=%b want all zero",
                     out_valid, out_data, out_chan, in_ready);
        end
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 8'h01) begin
            errors++;
            $display("FAIL reset_first_ready: got %b want 00000001", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 3'd0 || out_data !== 8'h10) begin
            errors++;
            $display("FAIL reset_first_grant: valid=%b chan=%0d data=%h want 1/0/10",
                     out_valid, out_chan, out_data);
        end
        @(negedge clk);
        out_ready = 1'b1;
    endtask

    task automatic test_random();
        logic [CH-1:0] er;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) sel = SW'($urandom);
            in_valid  = ($urandom_range(0, 5) == 0) ? '0 : CH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < CH; k++) in_data[k*W +: W] = 8'($urandom);
            #1;
            er = exp_ready();
            checks++;
            if (in_ready !== er) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready, er);
            end
            tick();
            checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_chan !== SW'(m_chan)) begin
                errors++;
                $display("FAIL rand_out[%0d]: valid=%b data=%h chan=%0d want %b/%h/%0d",
                         n, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        model_reset();
        test_reset();
        test_fixed();
        test_rr_sweep();
        test_wrap();
        test_stall();
        test_sel_change();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
